// File: rtl/sprite_lookup_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_lookup_pkg
// Brief    : Sprite register field layout, background code and FSM states.
// Revision : 1.0
// ============================================================================
package sprite_lookup_pkg;

    localparam int ACTIVE_BIT = 31;
    localparam int X_MSB      = 30;
    localparam int X_LSB      = 21;
    localparam int Y_MSB      = 20;
    localparam int Y_LSB      = 11;
    localparam int OFF_MSB    = 10;
    localparam int OFF_LSB    = 0;

    localparam logic [31:0] BG_CODE = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sprite_hit_cmp.sv
`default_nettype none
// ============================================================================
// Module   : sprite_hit_cmp
// Brief    : Combinational test of whether an active sprite covers a pixel.
// Revision : 1.0
// ============================================================================
module sprite_hit_cmp
    import sprite_lookup_pkg::*;
#(
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int SPRITE_DIM = 20
) (
    input  logic [31:0]       reg_i,
    input  logic [SIZE_X-1:0] px_i,
    input  logic [SIZE_Y-1:0] py_i,
    output logic              hit_o
);

    // One extra bit keeps the far edge of a sprite near the top of the range from wrapping.
    logic [SIZE_X:0] w_x_lo;
    logic [SIZE_X:0] w_x_hi;
    logic [SIZE_Y:0] w_y_lo;
    logic [SIZE_Y:0] w_y_hi;
    logic [SIZE_X:0] w_px;
    logic [SIZE_Y:0] w_py;
    logic            w_in_x;
    logic            w_in_y;
    logic            w_unused_off;

    assign w_x_lo = (SIZE_X+1)'(reg_i[X_MSB:X_LSB]);
    assign w_y_lo = (SIZE_Y+1)'(reg_i[Y_MSB:Y_LSB]);
    assign w_x_hi = w_x_lo + (SIZE_X+1)'(SPRITE_DIM);
    assign w_y_hi = w_y_lo + (SIZE_Y+1)'(SPRITE_DIM);
    assign w_px   = {1'b0, px_i};
    assign w_py   = {1'b0, py_i};

    assign w_in_x = (w_px >= w_x_lo) && (w_px < w_x_hi);
    assign w_in_y = (w_py >= w_y_lo) && (w_py < w_y_hi);
    assign hit_o  = reg_i[ACTIVE_BIT] && w_in_x && w_in_y;

    // The memory offset field plays no part in the bounds test.
    assign w_unused_off = ^reg_i[OFF_MSB:OFF_LSB];

endmodule
`default_nettype wire

// File: rtl/sprite_lookup_bank.sv
`default_nettype none
// ============================================================================
// Module   : sprite_lookup_bank
// Brief    : Sprite register bank answering {x,y} queries with the first
//            covering sprite; COLLISION_DETECT_EN enables full-scan collision flag.
// Revision : 1.0
// ============================================================================
module sprite_lookup_bank
    import sprite_lookup_pkg::*;
#(
    parameter int N_REGS     = 32,
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int SPRITE_DIM = 20,
    parameter int IDX_W      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     check_valid,
    input  logic [SIZE_X+SIZE_Y-1:0] check_value,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_addr,
    input  logic [31:0]              wr_data,
    output logic [31:0]              data_reg,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     collision
);

    logic [31:0]       regs_q [N_REGS];
    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [SIZE_X-1:0] px_q;
    logic [SIZE_Y-1:0] py_q;
    logic [31:0]       data_reg_q;
    logic              data_valid_q;
    logic              busy_q;

    logic              w_wr_addr_ok;
    logic [31:0]       w_cur;
    logic              w_hit;
    logic              w_last;

`ifdef COLLISION_DETECT_EN
    logic [31:0]       first_q;
    logic              found_q;
    logic              multi_q;
    logic              collision_q;
`endif

    generate
        if (N_REGS < (1 << IDX_W)) begin : g_addr_chk
            assign w_wr_addr_ok = (32'(wr_addr) < 32'(N_REGS));
        end else begin : g_addr_full
            assign w_wr_addr_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && w_wr_addr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Reads the pre-write value, so a same-cycle write to the entry under test is seen next cycle.
    assign w_cur  = regs_q[idx_q];
    assign w_last = (idx_q == IDX_W'(N_REGS - 1));

    sprite_hit_cmp #(
        .SIZE_X     (SIZE_X),
        .SIZE_Y     (SIZE_Y),
        .SPRITE_DIM (SPRITE_DIM)
    ) u_hit_cmp (
        .reg_i (w_cur),
        .px_i  (px_q),
        .py_i  (py_q),
        .hit_o (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            data_reg_q   <= BG_CODE;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef COLLISION_DETECT_EN
            first_q      <= BG_CODE;
            found_q      <= 1'b0;
            multi_q      <= 1'b0;
            collision_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_valid_q <= 1'b0;
                    if (check_valid) begin
                        px_q    <= check_value[SIZE_X+SIZE_Y-1:SIZE_Y];
                        py_q    <= check_value[SIZE_Y-1:0];
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
`ifdef COLLISION_DETECT_EN
                        found_q <= 1'b0;
                        multi_q <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
`ifdef COLLISION_DETECT_EN
                    if (w_hit) begin
                        if (!found_q) begin
                            first_q <= w_cur;
                            found_q <= 1'b1;
                        end else begin
                            multi_q <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        data_reg_q   <= found_q ? first_q : (w_hit ? w_cur : BG_CODE);
                        collision_q  <= multi_q || (w_hit && found_q);
                        data_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
`else
                    if (w_hit) begin
                        data_reg_q   <= w_cur;
                        data_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end else if (w_last) begin
                        data_reg_q   <= BG_CODE;
                        data_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    data_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
`ifdef COLLISION_DETECT_EN
                    collision_q  <= 1'b0;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_reg   = data_reg_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
`ifdef COLLISION_DETECT_EN
    assign collision  = collision_q;
`else
    assign collision  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_lookup_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_lookup_bank
// Brief    : Self-checking bench for sprite_lookup_bank (either COLLISION_DETECT_EN build).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sprite_lookup_bank;

    localparam int          N_REGS = 32;
    localparam logic [31:0] BG     = 32'h0000_0001;
`ifdef COLLISION_DETECT_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        check_valid = 1'b0;
    logic [19:0] check_value = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] data_reg;
    logic        data_valid;
    logic        busy;
    logic        collision;

    sprite_lookup_bank dut (
        .clk         (clk),
        .reset       (reset),
        .check_valid (check_valid),
        .check_value (check_value),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .data_reg    (data_reg),
        .data_valid  (data_valid),
        .busy        (busy),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        coll;
        int          lat;
        int          start;
        string       name;
    } exp_t;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] d;
        logic        c;
        int          hidx;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   dv_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk(input logic [9:0] x, input logic [9:0] y);
        return {1'b1, x, y, 11'h055};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard: every data_valid pulse must match the oldest pending query.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data_valid: got data_reg %h expected no pulse", data_reg);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_data"}, data_reg, e.data);
                chk({e.name, "_coll"}, {31'b0, collision}, {31'b0, e.coll});
                chk({e.name, "_lat"}, 32'(cyc - e.start), 32'(e.lat));
            end
        end
    end

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic query(input logic [9:0] x, input logic [9:0] y, input logic [31:0] d,
                         input logic c, input int hidx, input string name);
        exp_t e;
        @(negedge clk);
        e.data  = d;
        e.coll  = COLL_EN ? c : 1'b0;
        e.lat   = (COLL_EN || hidx < 0) ? N_REGS + 1 : hidx + 2;
        e.start = cyc;
        e.name  = name;
        exp_q.push_back(e);
        check_valid = 1'b1;
        check_value = {x, y};
        @(negedge clk);
        check_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no data_valid within %0d cycles expected one", name, n);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[13];
        logic [31:0] r0, r2, r3, r7;
        int          dv0;
        int          n;
        bit          busy_ok;

        r0 = mk(10'd1015, 10'd470);
        r2 = mk(10'd190, 10'd190);
        r3 = mk(10'd100, 10'd50);
        r7 = mk(10'd195, 10'd195);

        tbl[0]  = '{10'd110,  10'd60,  r3, 1'b0,  3, "q_110_60"};
        tbl[1]  = '{10'd120,  10'd60,  BG, 1'b0, -1, "q_120_60"};
        tbl[2]  = '{10'd119,  10'd69,  r3, 1'b0,  3, "q_119_69"};
        tbl[3]  = '{10'd99,   10'd60,  BG, 1'b0, -1, "q_99_60"};
        tbl[4]  = '{10'd100,  10'd50,  r3, 1'b0,  3, "q_100_50"};
        tbl[5]  = '{10'd200,  10'd200, r2, 1'b1,  2, "q_200_200"};
        tbl[6]  = '{10'd192,  10'd192, r2, 1'b0,  2, "q_192_192"};
        tbl[7]  = '{10'd212,  10'd212, r7, 1'b0,  7, "q_212_212"};
        tbl[8]  = '{10'd5,    10'd475, BG, 1'b0, -1, "q_nowrap"};
        tbl[9]  = '{10'd1020, 10'd475, r0, 1'b0,  0, "q_1020_475"};
        tbl[10] = '{10'd1023, 10'd489, r0, 1'b0,  0, "q_1023_489"};
        tbl[11] = '{10'd1023, 10'd490, BG, 1'b0, -1, "q_1023_490"};
        tbl[12] = '{10'd305,  10'd305, BG, 1'b0, -1, "q_inactive"};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data_reg", data_reg, BG);
        chk("rst_data_valid", {31'b0, data_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_collision", {31'b0, collision}, 32'd0);

        query(10'd100, 10'd100, BG, 1'b0, -1, "empty_bank");
        wait_idle("empty_bank");

        write_reg(5'd0, r0);
        write_reg(5'd2, r2);
        write_reg(5'd3, r3);
        write_reg(5'd5, {1'b0, 10'd300, 10'd300, 11'h0});
        write_reg(5'd7, r7);

        for (int i = 0; i < 13; i++) begin
            query(tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].c, tbl[i].hidx, tbl[i].name);
            wait_idle(tbl[i].name);
        end

        // reg3 is overwritten in the very cycle it is compared: old contents still win.
        @(negedge clk);
        begin
            exp_t e;
            e.data  = r3;
            e.coll  = 1'b0;
            e.lat   = COLL_EN ? N_REGS + 1 : 5;
            e.start = cyc;
            e.name  = "same_cycle_wr";
            exp_q.push_back(e);
        end
        check_valid = 1'b1;
        check_value = {10'd110, 10'd60};
        @(negedge clk);
        check_valid = 1'b0;
        repeat (3) @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle("same_cycle_wr");
        query(10'd110, 10'd60, BG, 1'b0, -1, "after_clear3");
        wait_idle("after_clear3");
        write_reg(5'd3, r3);

        // Extra check_valid strobes during the scan must be dropped.
        dv0 = dv_count;
        query(10'd100, 10'd100, BG, 1'b0, -1, "ignore_cv");
        busy_ok = 1'b1;
        n = 0;
        while (!data_valid && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            check_valid = (n == 1 || n == 2 || n == 9);
            check_value = 20'($urandom);
            @(negedge clk);
            n++;
        end
        check_valid = 1'b0;
        if (!busy) busy_ok = 1'b0;
        wait_idle("ignore_cv");
        repeat (40) @(negedge clk);
        chk("ignore_cv_one_pulse", 32'(dv_count - dv0), 32'd1);
        chk("ignore_cv_busy_high", {31'b0, busy_ok}, 32'd1);

        query(10'd110, 10'd60, r3, 1'b0, 3, "pre_reset_hit");
        wait_idle("pre_reset_hit");

        // Reset in the middle of a long scan.
        dv0 = dv_count;
        @(negedge clk);
        check_valid = 1'b1;
        check_value = {10'd5, 10'd475};
        @(negedge clk);
        check_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("midscan_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("midscan_no_pulse", 32'(dv_count - dv0), 32'd0);
        chk("midscan_data_reg", data_reg, BG);
        chk("midscan_busy_low", {31'b0, busy}, 32'd0);

        query(10'd110, 10'd60, BG, 1'b0, -1, "post_rst_110_60");
        wait_idle("post_rst_110_60");
        query(10'd1020, 10'd475, BG, 1'b0, -1, "post_rst_1020");
        wait_idle("post_rst_1020");
        query(10'd200, 10'd200, BG, 1'b0, -1, "post_rst_200");
        wait_idle("post_rst_200");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
